vec_mag_sqrt_iter: RTL
======================

// Module: vec_mag_sqrt_iter
// PURPOSE
//   Parametrised, multi-cycle vector-magnitude unit: computes floor(sqrt(x*x + y*y)).
//   Digit-by-digit (restoring) integer square root, one result bit per clock.
//   Uses a start/ready/done handshake; result is held until the next accepted start.
//   Sits behind the tt_um top-level pin wrapper; ui_in supplies x and uio_in supplies y.
// PARAMETERS
//   W       8   width of each operand x, y
//   SIGNED  0   1: x, y are two's complement, magnitude uses |x|, |y|; 0: unsigned
// PORTS
//   clk     in   1     single clock, rising edge
//   rst     in   1     asynchronous, active-high reset
//   start   in   1     request; sampled only while ready=1
//   x       in   W     operand x
//   y       in   W     operand y
//   ready   out  1     1 in IDLE only
//   busy    out  1     1 in SUM and ITER
//   done    out  1     single-cycle pulse; result valid from this cycle on
//   mag     out  W+1   magnitude result
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, mag=0, internals=0.
//   States: IDLE -> SUM -> ITER -> DONE -> IDLE.
//   IDLE: on an edge with start=1, latch x and y (after |.| when SIGNED=1), go to SUM.
//   SUM (1 cycle): S = x*x + y*y, held in a 2W+1 bit register; no truncation.
//     SIGNED=1 with x = -2^(W-1): |x| = 2^(W-1), which fits in W bits unsigned.
//   ITER (exactly W+1 cycles): restoring sqrt with 2W+2 bit rem/trial regs, MSB pair first;
//     per step: trial = (root<<2)|1 on the shifted remainder; if rem >= trial then
//     subtract and shift in 1, else shift in 0. Iteration counter width = clog2(W+2).
//   DONE (1 cycle): mag <= root, done=1, ready=0, busy=0; next state IDLE.
//   Latency: done is high after the (W+2)th rising edge following the accepting edge
//     (W=8: 10 edges). Throughput: one result per W+4 cycles.
//   start while busy/DONE: ignored, not queued. x/y changes after acceptance: no effect.
//   mag is stable between done pulses; it is updated only on entry to DONE.
//   Result range: max floor(sqrt(2)*(2^W-1)) < 2^(W+1), so mag never overflows.
//   Reset mid-operation: computation abandoned, mag cleared to 0, no done pulse.
// CONFIGURATION
//   VMAG_ROUND_EN defined: DONE outputs round-to-nearest. mag = root+1 if
//     S - root^2 > root, else root. root+1 <= 2^(W+1)-1 always (no overflow).
//     Latency and handshake are unchanged.
//   VMAG_ROUND_EN undefined: mag = floor(sqrt(S)); the rounding compare is not generated.
// TESTING (W=8 unless stated)
//   T1 x=3,y=4 start -> done after 10 edges, mag=5 (both builds).
//   T2 x=255,y=255 (S=130050) -> mag=360; with VMAG_ROUND_EN -> 361.
//   T3 x=0,y=0 -> mag=0; x=1,y=1 -> mag=1 (both builds); x=2,y=1 -> 2 (both builds).
//   T4 SIGNED=1: x=8'hFD,y=8'hFC -> mag=5; x=8'h80,y=8'h80 -> mag=181.
//   T5 start held high through a run with x/y changed at cycle 3 -> exactly one done,
//      result from the latched operands; next request accepted only after ready=1.
//   T6 rst pulse at ITER cycle 4 -> immediately ready=1, busy=0, mag=0, no done;
//      a new start after reset returns the correct result.

Source files
------------

// File: rtl/vec_mag_sqrt_iter_if.sv
// Handshake bundle for vec_mag_sqrt_iter.
// master issues start/x/y; slave returns ready/busy/done/mag.
interface vec_mag_sqrt_iter_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W:0]   mag;

  modport master (
    output start, x, y,
    input  ready, busy, done, mag
  );

  modport slave (
    input  start, x, y,
    output ready, busy, done, mag
  );
endinterface

// File: rtl/vec_mag_sqrt_iter.sv
// Multi-cycle floor(sqrt(x*x+y*y)), one root bit per clock.
// Define VMAG_ROUND_EN for round-to-nearest output.
module vec_mag_sqrt_iter #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic clk,
  input  logic rst,
  vec_mag_sqrt_iter_if.slave bus
);
  localparam int SW = 2*W + 1;
  localparam int RW = 2*W + 2;
  localparam int MW = W + 1;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    ITER,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  x_q, y_q, ax, ay;
  logic [SW-1:0] s_q;
  logic [RW-1:0] rem_q, rem_sh, trial, rem_d;
  logic [MW-1:0] root_q, root_d, mag_q, mag_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    pair;
  logic          last;
  logic          ready, busy, done;

  // operand magnitude before latching
  always_comb begin
    ax = bus.x;
    ay = bus.y;
    if (SIGNED) begin
      if (bus.x[W-1]) ax = ~bus.x + W'(1);
      if (bus.y[W-1]) ay = ~bus.y + W'(1);
    end
  end

  // one restoring step, MSB pair of S first
  always_comb begin
    pair   = 2'(RW'(s_q) >> (2*(W - int'(cnt_q))));
    rem_sh = (rem_q << 2) | RW'(pair);
    trial  = RW'({root_q, 2'b01});
    if (rem_sh >= trial) begin
      rem_d  = rem_sh - trial;
      root_d = (root_q << 1) | MW'(1);
    end else begin
      rem_d  = rem_sh;
      root_d = root_q << 1;
    end
    last = (cnt_q == CW'(W));
`ifdef VMAG_ROUND_EN
    mag_d = (rem_d > RW'(root_d)) ? root_d + MW'(1) : root_d;
`else
    mag_d = root_d;
`endif
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) state_d = SUM;
      end
      SUM: begin
        busy    = 1'b1;
        state_d = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath: latch, square-sum, iterate, publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      mag_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q <= ax;
            y_q <= ay;
          end
        end
        SUM: begin
          s_q    <= SW'(x_q) * SW'(x_q) + SW'(y_q) * SW'(y_q);
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= '0;
        end
        ITER: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last) mag_q <= mag_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.mag   = mag_q;
endmodule
